// File: rtl/pc_ctrl.sv
// Program-counter unit for the fetch stage: next-PC selection, exception entry/return
// with an EPC register, and a circular return-address stack.
module pc_ctrl #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             branch_take,
    input  logic [WIDTH-1:0] branch_tgt,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_tgt,
    input  logic             call,
    input  logic             ret,
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic [WIDTH-1:0] epc,
    output logic             exl,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(RAS_DEPTH);

    typedef enum logic {RUN, EXC} exc_state_t;

    exc_state_t       state, state_d;
    logic [WIDTH-1:0] pc_d, epc_d;
    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    top, top_inc;
    logic [PW:0]      count;
    logic             do_push, do_pop, do_repl, err_set;

    assign pc_next_seq = pc + WIDTH'(INC);
    assign top_inc     = top + PW'(1);
    assign exl         = (state == EXC);
    assign ras_empty   = (count == '0);
    assign ras_full    = (count == DEPTH_C);

    // Fixed-priority next-PC selection; an accepted exception or eret masks all RAS activity.
    always_comb begin
        pc_d    = pc;
        epc_d   = epc;
        state_d = state;
        do_push = 1'b0;
        do_pop  = 1'b0;
        do_repl = 1'b0;
        err_set = 1'b0;
        if (en) begin
            if (exc_req && state == RUN) begin
                pc_d    = EXC_VEC;
                epc_d   = pc;
                state_d = EXC;
            end else if (eret && state == EXC) begin
                pc_d    = epc;
                state_d = RUN;
            end else if (ret) begin
                if (ras_empty) begin
                    pc_d    = pc_next_seq;
                    err_set = 1'b1;
                end else begin
                    pc_d    = ras[top];
                    do_repl = call;
                    do_pop  = !call;
                end
            end else if (call || jump) begin
                pc_d    = jump_tgt;
                do_push = call;
                err_set = call && ras_full;
            end else if (branch_take) begin
                pc_d = branch_tgt;
            end else begin
                pc_d = pc_next_seq;
            end
        end
    end

    // Pushing onto a full stack lands on the oldest slot, so overwrite needs no special case.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_VEC;
            epc     <= '0;
            state   <= RUN;
            top     <= '0;
            count   <= '0;
            ras_err <= 1'b0;
        end else begin
            pc      <= pc_d;
            epc     <= epc_d;
            state   <= state_d;
            ras_err <= ras_err | err_set;
            if (do_push) begin
                ras[top_inc] <= pc_next_seq;
                top          <= top_inc;
                if (!ras_full) begin
                    count <= count + (PW + 1)'(1);
                end
            end else if (do_pop) begin
                top   <= top - PW'(1);
                count <= count - (PW + 1)'(1);
            end else if (do_repl) begin
                ras[top] <= pc_next_seq;
            end
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed scoreboard bench for pc_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_ctrl;

    localparam logic [7:0] RST = 8'h80, EN = 8'h40, BR = 8'h20, JMP = 8'h10;
    localparam logic [7:0] CAL = 8'h08, RET = 8'h04, EXC = 8'h02, ERT = 8'h01;
    localparam logic [3:0] XL = 4'h8, EM = 4'h4, FU = 4'h2, ER = 4'h1;

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [3:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0, en = 1'b0, branch_take = 1'b0, jump = 1'b0;
    logic        call = 1'b0, ret = 1'b0, exc_req = 1'b0, eret = 1'b0;
    logic [31:0] branch_tgt = '0, jump_tgt = '0;
    logic [31:0] pc, pc_next_seq, epc;
    logic        exl, ras_empty, ras_full, ras_err;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    pc_ctrl dut (
        .clk(clk), .reset(reset), .en(en),
        .branch_take(branch_take), .branch_tgt(branch_tgt),
        .jump(jump), .jump_tgt(jump_tgt),
        .call(call), .ret(ret), .exc_req(exc_req), .eret(eret),
        .pc(pc), .pc_next_seq(pc_next_seq), .epc(epc), .exl(exl),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input string nm, input logic [7:0] ctl,
                                 input logic [31:0] btgt, input logic [31:0] jtgt,
                                 input logic [31:0] xpc, input logic [31:0] xepc,
                                 input logic [3:0] xflags);
        exp_t e;
        {reset, en, branch_take, jump, call, ret, exc_req, eret} = ctl;
        branch_tgt = btgt;
        jump_tgt   = jtgt;
        @(posedge clk);
        #1;
        e.nm    = nm;
        e.pc    = xpc;
        e.epc   = xepc;
        e.flags = xflags;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [3:0]  act;
        logic [31:0] seq_exp;
        act     = {exl, ras_empty, ras_full, ras_err};
        seq_exp = e.pc + 32'd4;
        tests++;
        if (pc !== e.pc || epc !== e.epc || act !== e.flags || pc_next_seq !== seq_exp) begin
            fails++;
            $display("[TB] FAIL %s: got pc=%h seq=%h epc=%h flags(exl,empty,full,err)=%b, want pc=%h seq=%h epc=%h flags=%b",
                     e.nm, pc, pc_next_seq, epc, act, e.pc, seq_exp, e.epc, e.flags);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            checkOutput(sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // T1: reset then sequential fetch
        applyStimulus("reset0",   RST,      0, 0, 32'h3000, 0, EM);
        applyStimulus("reset1",   RST,      0, 0, 32'h3000, 0, EM);
        applyStimulus("seq1",     EN,       0, 0, 32'h3004, 0, EM);
        applyStimulus("seq2",     EN,       0, 0, 32'h3008, 0, EM);
        applyStimulus("seq3",     EN,       0, 0, 32'h300C, 0, EM);
        // T2: jump beats branch, then a lone branch
        applyStimulus("seq4",     EN,       0, 0, 32'h3010, 0, EM);
        applyStimulus("jmp_br",   EN|BR|JMP, 32'h3100, 32'h3200, 32'h3200, 0, EM);
        applyStimulus("branch",   EN|BR,    32'h3100, 0, 32'h3100, 0, EM);
        // T3: call / return
        applyStimulus("reset2",   RST|EN,   0, 0, 32'h3000, 0, EM);
        applyStimulus("seq5",     EN,       0, 0, 32'h3004, 0, EM);
        applyStimulus("seq6",     EN,       0, 0, 32'h3008, 0, EM);
        applyStimulus("call",     EN|CAL,   0, 32'h3400, 32'h3400, 0, 4'h0);
        applyStimulus("seq7",     EN,       0, 0, 32'h3404, 0, 4'h0);
        applyStimulus("ret",      EN|RET,   0, 0, 32'h300C, 0, EM);
        // T4: overflow and underflow of the RAS
        applyStimulus("call1",    EN|CAL,   0, 32'h5000, 32'h5000, 0, 4'h0);
        applyStimulus("call2",    EN|CAL,   0, 32'h5100, 32'h5100, 0, 4'h0);
        applyStimulus("call3",    EN|CAL,   0, 32'h5200, 32'h5200, 0, 4'h0);
        applyStimulus("call4",    EN|CAL,   0, 32'h5300, 32'h5300, 0, FU);
        applyStimulus("call5",    EN|CAL,   0, 32'h5400, 32'h5400, 0, FU|ER);
        applyStimulus("ret1",     EN|RET,   0, 0, 32'h5304, 0, ER);
        applyStimulus("ret2",     EN|RET,   0, 0, 32'h5204, 0, ER);
        applyStimulus("ret3",     EN|RET,   0, 0, 32'h5104, 0, ER);
        applyStimulus("ret4",     EN|RET,   0, 0, 32'h5004, 0, EM|ER);
        applyStimulus("ret5",     EN|RET,   0, 0, 32'h5008, 0, EM|ER);
        // T5: exception entry, ignored nesting, eret, and interaction with RAS requests
        applyStimulus("reset3",   RST,      0, 0, 32'h3000, 0, EM);
        applyStimulus("jmp3020",  EN|JMP,   0, 32'h3020, 32'h3020, 0, EM);
        applyStimulus("exc",      EN|EXC,   0, 0, 32'h4180, 32'h3020, XL|EM);
        applyStimulus("exc_nest", EN|EXC,   0, 0, 32'h4184, 32'h3020, XL|EM);
        applyStimulus("eret",     EN|ERT,   0, 0, 32'h3020, 32'h3020, EM);
        applyStimulus("eret_ign", EN|ERT,   0, 0, 32'h3024, 32'h3020, EM);
        applyStimulus("exc_call", EN|EXC|CAL, 0, 32'h6000, 32'h4180, 32'h3024, XL|EM);
        applyStimulus("eret_ret", EN|ERT|RET, 0, 0, 32'h3024, 32'h3024, EM);
        applyStimulus("call7000", EN|CAL,   0, 32'h7000, 32'h7000, 32'h3024, 4'h0);
        applyStimulus("ret_call", EN|RET|CAL, 0, 32'h7100, 32'h3028, 32'h3024, 4'h0);
        applyStimulus("ret_repl", EN|RET,   0, 0, 32'h7004, 32'h3024, EM);
        // T6: stall holds everything, reset overrides a stall
        applyStimulus("call7200", EN|CAL,   0, 32'h7200, 32'h7200, 32'h3024, 4'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall",  JMP|CAL|EXC, 0, 32'h8000, 32'h7200, 32'h3024, 4'h0);
        end
        applyStimulus("ret_stl",  EN|RET,   0, 0, 32'h7008, 32'h3024, EM);
        applyStimulus("call7300", EN|CAL,   0, 32'h7300, 32'h7300, 32'h3024, 4'h0);
        applyStimulus("rst_stl",  RST|JMP|CAL, 0, 32'h8000, 32'h3000, 0, EM);
        applyStimulus("seq_end",  EN,       0, 0, 32'h3004, 0, EM);

        {reset, en, branch_take, jump, call, ret, exc_req, eret} = '0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            fails++;
            tests++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
